// File: rtl/snake_pkg.sv
// Shared constants, direction encoding and FSM states for the snake movement controller.
package snake_pkg;

  localparam int W       = 11;
  localparam int MAX_LEN = 26;

  localparam logic [W-1:0] X_MAX  = 11'd630;
  localparam logic [W-1:0] Y_MAX  = 11'd470;
  localparam logic [W-1:0] INIT_X = 11'd320;
  localparam logic [W-1:0] INIT_Y = 11'd240;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_CALC   = 3'd2,
    S_UPDATE = 3'd3,
    S_SCAN   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return ((a ^ b) == 2'b10);
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Body-stack port bundle: strobes and new head position out, tail readout back in.
interface snake_move_ctrl_if;
  import snake_pkg::*;

  logic         stk_push;
  logic         stk_pop;
  logic         stk_obtener;
  logic [W-1:0] stk_pos_x;
  logic [W-1:0] stk_pos_y;
  logic [W-1:0] stk_tail_x;
  logic [W-1:0] stk_tail_y;

  modport master (
    output stk_push, stk_pop, stk_obtener, stk_pos_x, stk_pos_y,
    input  stk_tail_x, stk_tail_y
  );

  modport slave (
    input  stk_push, stk_pop, stk_obtener, stk_pos_x, stk_pos_y,
    output stk_tail_x, stk_tail_y
  );
endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head computation with reversal filtering.
// SNAKE_WRAP_WALLS_EN: wrap the head to the opposite edge instead of flagging a field exit.
module snake_next_head
  import snake_pkg::*;
#(
  parameter logic [W-1:0] STEP = 11'd10
) (
  input  logic [W-1:0] head_x,
  input  logic [W-1:0] head_y,
  input  dir_t         cur_dir,
  input  dir_t         req_dir,
  output logic [W-1:0] next_x,
  output logic [W-1:0] next_y,
  output dir_t         new_dir,
  output logic         out_of_field
);

  logic [W:0] sum_x_s;
  logic [W:0] sum_y_s;
  logic       under_x_s;
  logic       under_y_s;
  logic       over_x_s;
  logic       over_y_s;

  // Pick the effective direction, step one cell in W+1 bits, classify the result.
  always_comb begin
    new_dir = is_reverse(req_dir, cur_dir) ? cur_dir : req_dir;
    sum_x_s = {1'b0, head_x};
    sum_y_s = {1'b0, head_y};
    case (new_dir)
      DIR_UP:    sum_y_s = {1'b0, head_y} - {1'b0, STEP};
      DIR_RIGHT: sum_x_s = {1'b0, head_x} + {1'b0, STEP};
      DIR_DOWN:  sum_y_s = {1'b0, head_y} + {1'b0, STEP};
      DIR_LEFT:  sum_x_s = {1'b0, head_x} - {1'b0, STEP};
      default: begin
        sum_x_s = {1'b0, head_x};
        sum_y_s = {1'b0, head_y};
      end
    endcase
    // A borrow past zero leaves the extra top bit set.
    under_x_s = sum_x_s[W];
    under_y_s = sum_y_s[W];
    over_x_s  = !sum_x_s[W] && (sum_x_s > {1'b0, X_MAX});
    over_y_s  = !sum_y_s[W] && (sum_y_s > {1'b0, Y_MAX});
`ifdef SNAKE_WRAP_WALLS_EN
    if (under_x_s)     next_x = X_MAX;
    else if (over_x_s) next_x = {W{1'b0}};
    else               next_x = sum_x_s[W-1:0];
    if (under_y_s)     next_y = Y_MAX;
    else if (over_y_s) next_y = {W{1'b0}};
    else               next_y = sum_y_s[W-1:0];
    out_of_field = 1'b0;
`else
    next_x       = sum_x_s[W-1:0];
    next_y       = sum_y_s[W-1:0];
    out_of_field = under_x_s | over_x_s | under_y_s | over_y_s;
`endif
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Game-tick sequencer: moves or grows the snake through the body stack, then scans
// every stack slot for self-collision.
module snake_move_ctrl
  import snake_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [1:0]        dir,
  input  logic              food_hit,
  snake_move_ctrl_if.master stk,
  output logic [W-1:0]      head_x,
  output logic [W-1:0]      head_y,
  output logic [5:0]        len,
  output logic              busy,
  output logic              frame_done,
  output logic              game_over
);

  localparam logic [W-1:0] STEP      = 11'd10;
  localparam logic [4:0]   LAST_K    = 5'(MAX_LEN - 1);
  localparam logic [5:0]   MAX_LEN_L = 6'(MAX_LEN);

  state_t       state_r;
  logic [W-1:0] head_x_r;
  logic [W-1:0] head_y_r;
  dir_t         cur_dir_r;
  dir_t         req_dir_r;
  logic         food_r;
  logic [5:0]   len_r;
  logic         game_over_r;
  logic         busy_r;
  logic         frame_done_r;
  logic         push_r;
  logic         pop_r;
  logic         obt_r;
  logic [W-1:0] pos_x_r;
  logic [W-1:0] pos_y_r;
  logic [4:0]   k_r;
  logic [4:0]   cmp_k_r;
  logic         cmp_valid_r;

  logic [W-1:0] nh_x_s;
  logic [W-1:0] nh_y_s;
  dir_t         nh_dir_s;
  logic         nh_oof_s;
  logic         hit_s;

  snake_next_head #(
    .STEP(STEP)
  ) u_next_head (
    .head_x      (head_x_r),
    .head_y      (head_y_r),
    .cur_dir     (cur_dir_r),
    .req_dir     (req_dir_r),
    .next_x      (nh_x_s),
    .next_y      (nh_y_s),
    .new_dir     (nh_dir_s),
    .out_of_field(nh_oof_s)
  );

  // Readout for slot cmp_k_r arrives now; slot len-1 is the head itself.
  always_comb begin
    hit_s = 1'b0;
    if (cmp_valid_r && (({1'b0, cmp_k_r} + 6'd1) < len_r) &&
        (stk.stk_tail_x == head_x_r) && (stk.stk_tail_y == head_y_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Step sequencer with registered strobes and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_INIT;
      head_x_r     <= INIT_X;
      head_y_r     <= INIT_Y;
      cur_dir_r    <= DIR_RIGHT;
      req_dir_r    <= DIR_RIGHT;
      food_r       <= 1'b0;
      len_r        <= 6'd0;
      game_over_r  <= 1'b0;
      busy_r       <= 1'b1;
      frame_done_r <= 1'b0;
      push_r       <= 1'b0;
      pop_r        <= 1'b0;
      obt_r        <= 1'b0;
      pos_x_r      <= {W{1'b0}};
      pos_y_r      <= {W{1'b0}};
      k_r          <= 5'd0;
      cmp_k_r      <= 5'd0;
      cmp_valid_r  <= 1'b0;
    end else begin
      push_r       <= 1'b0;
      pop_r        <= 1'b0;
      obt_r        <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        S_INIT: begin
          push_r  <= 1'b1;
          pos_x_r <= INIT_X;
          pos_y_r <= INIT_Y;
          len_r   <= 6'd1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        S_IDLE: begin
          if (tick && !game_over_r) begin
            req_dir_r <= dir_t'(dir);
            food_r    <= food_hit;
            busy_r    <= 1'b1;
            state_r   <= S_CALC;
          end
        end
        S_CALC: begin
          cur_dir_r <= nh_dir_s;
          if (nh_oof_s) begin
            game_over_r  <= 1'b1;
            frame_done_r <= 1'b1;
            state_r      <= S_DONE;
          end else begin
            head_x_r <= nh_x_s;
            head_y_r <= nh_y_s;
            pos_x_r  <= nh_x_s;
            pos_y_r  <= nh_y_s;
            // A full body cannot grow, so food there just moves.
            if (food_r && (len_r < MAX_LEN_L)) begin
              push_r <= 1'b1;
              len_r  <= len_r + 6'd1;
            end else begin
              pop_r  <= 1'b1;
            end
            state_r <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          obt_r       <= 1'b1;
          k_r         <= 5'd0;
          cmp_valid_r <= 1'b0;
          state_r     <= S_SCAN;
        end
        S_SCAN: begin
          cmp_valid_r <= 1'b1;
          cmp_k_r     <= k_r;
          if (k_r == LAST_K) begin
            state_r <= S_DRAIN;
          end else begin
            obt_r <= 1'b1;
            k_r   <= k_r + 5'd1;
          end
        end
        S_DRAIN: begin
          cmp_valid_r  <= 1'b0;
          frame_done_r <= 1'b1;
          state_r      <= S_DONE;
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b1;
          state_r <= S_INIT;
        end
      endcase
      if (hit_s) begin
        game_over_r <= 1'b1;
      end
    end
  end

  assign stk.stk_push    = push_r;
  assign stk.stk_pop     = pop_r;
  assign stk.stk_obtener = obt_r;
  assign stk.stk_pos_x   = pos_x_r;
  assign stk.stk_pos_y   = pos_y_r;
  assign head_x          = head_x_r;
  assign head_y          = head_y_r;
  assign len             = len_r;
  assign busy            = busy_r;
  assign frame_done      = frame_done_r;
  assign game_over       = game_over_r;

endmodule
